// File: rtl/div_rr_sched.sv
// Round-robin scheduler sharing one combinational divider among N requesters.
// Results are tagged with the requester id and queued in a 2-entry output FIFO.
module div_rr_sched #(
  parameter int N           = 4,
  parameter int W0          = 16,
  parameter int W1          = 16,
  parameter int WQ          = 16,
  parameter int DIN1_SIGNED = 0,
  localparam int IDW        = $clog2(N),
  localparam int DW         = 1 + IDW + WQ
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      din0_valid,
  output logic [N-1:0]      din0_ready,
  input  logic [N*W0-1:0]   din0_data,
  input  logic [N-1:0]      din1_valid,
  output logic [N-1:0]      din1_ready,
  input  logic [N*W1-1:0]   din1_data,
  output logic              div_a_valid,
  input  logic              div_a_ready,
  output logic [W0-1:0]     div_a_data,
  output logic              div_b_valid,
  input  logic              div_b_ready,
  output logic [W1-1:0]     div_b_data,
  input  logic              div_q_valid,
  output logic              div_q_ready,
  input  logic [WQ-1:0]     div_q_data,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [DW-1:0]     dout_data
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] ptr_next;

  logic [N-1:0]   elig;
  logic           found;
  logic [IDW-1:0] pick;

  logic [W0-1:0]  sel_a;
  logic [W1-1:0]  sel_b;
  logic           div_zero;
  logic           busy;

  logic [DW-1:0]  fifo_mem [2];
  logic           rd_idx;
  logic           wr_idx;
  logic [1:0]     count;
  logic           full;
  logic           push;
  logic           pop;
  logic           div_fire;
  logic [DW-1:0]  push_data;
  logic [N-1:0]   ack_mask;

  assign elig = din0_valid & din1_valid;
  assign busy = (state == BUSY);
  assign full = (count == 2'd2);

  // Operand mux for the locked grant and divide-by-zero detection.
  always_comb begin
    sel_a = din0_data[int'(grant)*W0 +: W0];
    sel_b = din1_data[int'(grant)*W1 +: W1];
    if (DIN1_SIGNED != 0) begin
      div_zero = ($signed(sel_b) == $signed({W1{1'b0}}));
    end else begin
      div_zero = (sel_b == {W1{1'b0}});
    end
  end

  // First eligible requester scanning ptr, ptr+1, ... with wrap at N.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = ptr;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end else begin
        idx = idx;
      end
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end else begin
        found = found;
      end
    end
  end

  // Divider handshake, FIFO push decision and requester acknowledge.
  always_comb begin
    div_a_valid = busy & ~div_zero;
    div_b_valid = busy & ~div_zero;
    div_a_data  = sel_a;
    div_b_data  = sel_b;
    // Reset suppresses completion so no requester sees a spurious ready.
    div_q_ready = busy & ~rst & ~div_zero & ~full;
    div_fire    = div_q_valid & div_q_ready & div_a_ready & div_b_ready;
    push        = busy & ~rst & ~full & (div_zero | div_fire);
    if (div_zero) begin
      push_data = {1'b1, grant, {WQ{1'b1}}};
    end else begin
      push_data = {1'b0, grant, div_q_data};
    end
    if (push) begin
      ack_mask = {{(N-1){1'b0}}, 1'b1} << grant;
    end else begin
      ack_mask = {N{1'b0}};
    end
    din0_ready = ack_mask;
    din1_ready = ack_mask;
    if (int'(grant) == N - 1) begin
      ptr_next = {IDW{1'b0}};
    end else begin
      ptr_next = grant + {{(IDW-1){1'b0}}, 1'b1};
    end
  end

  // Arbitration state: grant is locked from selection until completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= {IDW{1'b0}};
      grant <= {IDW{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (push) begin
            ptr   <= ptr_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop        = dout_valid & dout_ready;
  assign dout_valid = (count != 2'd0);
  assign dout_data  = fifo_mem[rd_idx];

  // FIFO pointers and occupancy; full is judged before any same-cycle pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx <= 1'b0;
      wr_idx <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        wr_idx <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: tb/tb_div_rr_sched.sv
// Directed bench for div_rr_sched with a queue-based reference model and a
// behavioural combinational divider standing in for the shared div.
module tb_div_rr_sched;

  localparam int N  = 4;
  localparam int W0 = 16;
  localparam int W1 = 16;
  localparam int WQ = 16;
  localparam int DW = 19;

  logic            clk;
  logic            rst;
  logic [N-1:0]    din0_valid, din0_ready, din1_valid, din1_ready;
  logic [N*W0-1:0] din0_data;
  logic [N*W1-1:0] din1_data;
  logic            div_a_valid, div_a_ready, div_b_valid, div_b_ready;
  logic [W0-1:0]   div_a_data;
  logic [W1-1:0]   div_b_data;
  logic            div_q_valid, div_q_ready;
  logic [WQ-1:0]   div_q_data;
  logic            dout_valid, dout_ready;
  logic [DW-1:0]   dout_data;

  div_rr_sched #(.N(N), .W0(W0), .W1(W1), .WQ(WQ), .DIN1_SIGNED(0)) dut (
    .clk(clk), .rst(rst),
    .din0_valid(din0_valid), .din0_ready(din0_ready), .din0_data(din0_data),
    .din1_valid(din1_valid), .din1_ready(din1_ready), .din1_data(din1_data),
    .div_a_valid(div_a_valid), .div_a_ready(div_a_ready), .div_a_data(div_a_data),
    .div_b_valid(div_b_valid), .div_b_ready(div_b_ready), .div_b_data(div_b_data),
    .div_q_valid(div_q_valid), .div_q_ready(div_q_ready), .div_q_data(div_q_data),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data)
  );

  // Stand-in combinational divider.
  assign div_q_valid = div_a_valid & div_b_valid;
  assign div_q_data  = (div_b_data == 16'd0) ? 16'hFFFF : (div_a_data / div_b_data);
  assign div_a_ready = div_q_ready;
  assign div_b_ready = div_q_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit auto_drop = 1'b1;
  int cyc = 0;

  bit            m_busy;
  int            m_grant;
  int            m_ptr;
  int            m_acked;
  logic [DW-1:0] m_fifo[$];

  logic [DW-1:0] popped[$];
  int            pop_cyc[$];
  int            rdy2_cnt;
  int            div_seen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [15:0] a_of(input int i);
    return din0_data[i*W0 +: W0];
  endfunction

  function automatic logic [15:0] b_of(input int i);
    return din1_data[i*W1 +: W1];
  endfunction

  // Reference model: grant one request at a time, queue tagged results.
  always @(posedge clk) begin : model
    bit            full, pop, do_push;
    logic [DW-1:0] e;
    int            j;
    cyc++;
    m_acked = -1;
    if (rst) begin
      m_busy = 1'b0;
      m_ptr = 0;
      m_grant = 0;
      m_fifo.delete();
    end else begin
      full = (m_fifo.size() == 2);
      pop = (m_fifo.size() > 0) && dout_ready;
      do_push = 1'b0;
      e = '0;
      if (m_busy && !full) begin
        if (b_of(m_grant) == 16'd0) e = {1'b1, 2'(m_grant), 16'hFFFF};
        else e = {1'b0, 2'(m_grant), 16'(a_of(m_grant) / b_of(m_grant))};
        do_push = 1'b1;
        m_acked = m_grant;
        m_busy = 1'b0;
        m_ptr = (m_grant + 1) % N;
      end else if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          j = (m_ptr + k) % N;
          if (!m_busy && din0_valid[j] && din1_valid[j]) begin
            m_busy = 1'b1;
            m_grant = j;
          end
        end
      end
      if (pop) void'(m_fifo.pop_front());
      if (do_push) m_fifo.push_back(e);
    end
  end

  // Compare DUT outputs with the model every cycle, and log observations.
  always @(negedge clk) begin : compare
    bit full, zero;
    if (chk_en) begin
      full = (m_fifo.size() == 2);
      zero = m_busy && (b_of(m_grant) == 16'd0);
      chk("dout_valid", 32'(dout_valid), 32'(m_fifo.size() > 0));
      if (m_fifo.size() > 0) chk("dout_data", 32'(dout_data), 32'(m_fifo[0]));
      chk("din0_ready", 32'(din0_ready), (!rst && m_busy && !full) ? 32'(1 << m_grant) : 32'd0);
      chk("din1_ready", 32'(din1_ready), (!rst && m_busy && !full) ? 32'(1 << m_grant) : 32'd0);
      chk("div_a_valid", 32'(div_a_valid), 32'(m_busy && !zero));
      chk("div_b_valid", 32'(div_b_valid), 32'(m_busy && !zero));
      chk("div_q_ready", 32'(div_q_ready), 32'(!rst && m_busy && !zero && !full));
      if (m_busy && !zero) begin
        chk("div_a_data", 32'(div_a_data), 32'(a_of(m_grant)));
        chk("div_b_data", 32'(div_b_data), 32'(b_of(m_grant)));
      end
    end
    if (dout_valid && dout_ready) begin
      popped.push_back(dout_data);
      pop_cyc.push_back(cyc);
    end
    if (din0_ready[2]) rdy2_cnt++;
    if (div_a_valid) div_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_drop && m_acked >= 0) begin
      din0_valid[m_acked] = 1'b0;
      din1_valid[m_acked] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    din0_data[i*W0 +: W0] = a;
    din1_data[i*W1 +: W1] = b;
    din0_valid[i] = 1'b1;
    din1_valid[i] = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    din0_valid = '0; din1_valid = '0;
    din0_data = '0; din1_data = '0;
    dout_ready = 1'b0;
    rdy2_cnt = 0; div_seen = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset dout_valid", 32'(dout_valid), 32'd0);
    chk("reset div_a_valid", 32'(div_a_valid), 32'd0);
    chk("reset din_ready", 32'({din0_ready, din1_ready}), 32'd0);
    tick();
    rst = 1'b0;

    // 1: single request 100/7 from requester 2
    dout_ready = 1'b1; auto_drop = 1'b1;
    popped.delete(); rdy2_cnt = 0;
    set_req(2, 16'd100, 16'd7);
    tick(); tick();
    @(negedge clk);
    chk("t1 dout_valid", 32'(dout_valid), 32'd1);
    chk("t1 dout_data", 32'(dout_data), 32'({1'b0, 2'd2, 16'd14}));
    repeat (4) tick();
    chk("t1 ready pulses", 32'(rdy2_cnt), 32'd1);

    // 2: all four held with ptr=0, round-robin order and 2-cycle spacing
    do_reset();
    popped.delete(); pop_cyc.delete();
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 16'((i + 1) * 60), 16'(i + 3));
    repeat (12) tick();
    auto_drop = 1'b1;
    n = 0;
    while ((din0_valid != '0) && n < 40) begin tick(); n++; end
    repeat (4) tick();
    chk("t2 drained", 32'(din0_valid), 32'd0);
    chk("t2 count", 32'(popped.size() >= 5), 32'd1);
    if (popped.size() >= 5) begin
      chk("t2 id0", 32'(popped[0][17:16]), 32'd0);
      chk("t2 id1", 32'(popped[1][17:16]), 32'd1);
      chk("t2 id2", 32'(popped[2][17:16]), 32'd2);
      chk("t2 id3", 32'(popped[3][17:16]), 32'd3);
      chk("t2 id4", 32'(popped[4][17:16]), 32'd0);
      chk("t2 q2", 32'(popped[2]), 32'({1'b0, 2'd2, 16'd36}));
      chk("t2 spacing", 32'(pop_cyc[1] - pop_cyc[0]), 32'd2);
    end

    // 3: divide by zero from requester 1
    popped.delete(); div_seen = 0;
    set_req(1, 16'd55, 16'd0);
    tick(); tick();
    @(negedge clk);
    chk("t3 dout_data", 32'(dout_data), 32'({1'b1, 2'd1, 16'hFFFF}));
    repeat (3) tick();
    chk("t3 div unused", 32'(div_seen), 32'd0);
    chk("t3 acked", 32'(din0_valid[1]), 32'd0);

    // 4: back-pressure with three requests, then drain in order
    do_reset();
    dout_ready = 1'b0;
    popped.delete();
    set_req(0, 16'd40, 16'd8);
    set_req(1, 16'd81, 16'd9);
    set_req(2, 16'd7, 16'd7);
    repeat (8) tick();
    @(negedge clk);
    chk("t4 held q_ready", 32'(div_q_ready), 32'd0);
    chk("t4 held din ready", 32'(din0_ready), 32'd0);
    chk("t4 head id", 32'(dout_data[17:16]), 32'd0);
    chk("t4 req2 pending", 32'(din0_valid[2]), 32'd1);
    dout_ready = 1'b1;
    repeat (10) tick();
    chk("t4 drain count", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) begin
      chk("t4 q0", 32'(popped[0]), 32'({1'b0, 2'd0, 16'd5}));
      chk("t4 q1", 32'(popped[1]), 32'({1'b0, 2'd1, 16'd9}));
      chk("t4 q2", 32'(popped[2]), 32'({1'b0, 2'd2, 16'd1}));
    end

    // 5: only one half valid is never granted
    popped.delete();
    din0_data[3*W0 +: W0] = 16'd9;
    din1_data[3*W1 +: W1] = 16'd3;
    din0_valid[3] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      chk("t5 no ready", 32'({din0_ready, din1_ready}), 32'd0);
    end
    din1_valid[3] = 1'b1;
    n = 0;
    while (popped.size() == 0 && n < 10) begin tick(); n++; end
    chk("t5 served", 32'(popped.size()), 32'd1);
    if (popped.size() > 0) chk("t5 data", 32'(popped[0]), 32'({1'b0, 2'd3, 16'd3}));

    // 6: reset while BUSY with one buffered result
    do_reset();
    dout_ready = 1'b0;
    popped.delete();
    set_req(0, 16'd20, 16'd4);
    set_req(1, 16'd30, 16'd5);
    tick(); tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6 no pulse", 32'({din0_ready, din1_ready}), 32'd0);
    chk("t6 buffered", 32'(dout_valid), 32'd1);
    tick();
    rst = 1'b0;
    set_req(0, 16'd8, 16'd2);
    @(negedge clk);
    chk("t6 flushed", 32'(dout_valid), 32'd0);
    dout_ready = 1'b1;
    n = 0;
    while (popped.size() < 2 && n < 20) begin tick(); n++; end
    chk("t6 served", 32'(popped.size()), 32'd2);
    if (popped.size() >= 2) begin
      chk("t6 first", 32'(popped[0]), 32'({1'b0, 2'd0, 16'd4}));
      chk("t6 second", 32'(popped[1]), 32'({1'b0, 2'd1, 16'd6}));
    end
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
